// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter: async-reset register with +4 increment and redirect load.
module pc_reg #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // load has priority so a redirect always beats the sequential step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + ADDR_WIDTH'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch with valid/ready output and PC redirect.
// Optional build macro FETCH_MISALIGN_CHECK_EN halts on a misaligned redirect target.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_misalign
);

  fetch_state_e          state, state_nxt;
  logic                  drop, drop_nxt;
  logic                  pc_inc, pc_load, capture;
  logic                  misalign_hit;
  logic [ADDR_WIDTH-1:0] pc, target;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target         = redirect_pc;
  assign misalign_hit   = (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = (state == S_HALT);
`else
  assign target         = redirect_pc & ~ADDR_WIDTH'(3);
  assign misalign_hit   = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (target),
    .pc      (pc)
  );

  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_valid) begin
          drop_nxt = 1'b0;
          if (drop) begin
            state_nxt = S_REQ;
          end else begin
            capture   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: if (instr_ready) state_nxt = S_REQ;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_REQ;
    endcase
    // Redirect overrides everything; a response still owed by memory must be
    // swallowed before the new-path request goes out.
    if (redirect && (state != S_HALT)) begin
      capture  = 1'b0;
      pc_inc   = 1'b0;
      drop_nxt = 1'b0;
      if (misalign_hit) begin
        state_nxt = S_HALT;
      end else begin
        pc_load = 1'b1;
        if ((state == S_WAIT) && !imem_valid) begin
          drop_nxt  = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  // A request issued under a redirect would leave an orphan response behind.
  assign imem_req    = rst && (state == S_REQ) && !redirect;
  assign imem_addr   = pc;
  assign instr_valid = (state == S_HOLD);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc;
  int unsigned lat;
  int          n_cmp;
  int          n_mis;
  int          ndeliv;
  logic [31:0] exp_pc;
  bit          halted;

  bit          s_req, s_vin, s_ivld, s_mis, s_deliv;
  logic [31:0] s_addr, s_instr, s_dpc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: drive at the falling edge, sample shortly after, update the model.
  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = memf(mq[0].addr);
      void'(mq.pop_front());
    end
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_vin   = imem_valid;
    s_ivld  = instr_valid;
    s_instr = instr;
    s_dpc   = instr_pc;
    s_mis   = fetch_misalign;
    s_deliv = instr_valid && instr_ready;
    if (imem_req) begin
      chk("req_addr", imem_addr, exp_pc);
      mq.push_back('{due: cyc + lat, addr: imem_addr});
    end
    if (s_deliv && !halted) begin
      chk("dlv_pc", instr_pc, exp_pc);
      chk("dlv_instr", instr, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ndeliv++;
    end
    if (rd && !halted) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) halted = 1'b1;
      else exp_pc = rpc;
`else
      exp_pc = rpc & ~32'h3;
`endif
    end
    cyc++;
  endtask

  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2;
    rst         = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    imem_valid  = 1'b0;
    #1;
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_ivld"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_ipc"}, instr_pc, 32'h0);
    chk({tag, "_mis"}, 32'(fetch_misalign), 32'd0);
    mq.delete();
    exp_pc = 32'h0;
    halted = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk({tag, "_req_held"}, 32'(imem_req), 32'd0);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_req) break;
    end
    chk(tag, 32'(s_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rc[$];
    logic [31:0] ra[$];
    int          n, nd;
    logic [31:0] rpc;
    bit          rdy, rd;

    imem_valid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    lat = 1; cyc = 0; n_cmp = 0; n_mis = 0; ndeliv = 0;
    exp_pc = 32'h0; halted = 1'b0;

    reset_pulse("rst_init");

    // Back-to-back stream with 1-cycle memory and decode always ready
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_req) begin
        rc.push_back(cyc - 1);
        ra.push_back(s_addr);
      end
    end
    chk("t1_nreq", ra.size(), 32'd4);
    if (ra.size() >= 3) begin
      chk("t1_a0", ra[0], 32'h0);
      chk("t1_a1", ra[1], 32'h4);
      chk("t1_a2", ra[2], 32'h8);
      chk("t1_gap1", rc[1] - rc[0], 32'd3);
      chk("t1_gap2", rc[2] - rc[1], 32'd3);
    end

    // Redirect in the same cycle as the memory response
    wait_req("c_sync");
    step(1'b1, 1'b1, 32'h200);
    chk("c_vld_same", 32'(s_vin), 32'd1);
    nd = ndeliv;
    step(1'b1, 1'b0, 32'h0);
    chk("c_req", 32'(s_req), 32'd1);
    chk("c_addr", s_addr, 32'h200);
    chk("c_ivld", 32'(s_ivld), 32'd0);
    chk("c_no_dlv", ndeliv, nd);

    // Redirect while waiting on a slow memory: stale response must be dropped
    lat = 3;
    wait_req("d_sync");
    step(1'b1, 1'b1, 32'h100);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
      if (s_req) break;
    end
    chk("d_req_seen", 32'(s_req), 32'd1);
    chk("d_gap", n, 32'd3);
    chk("d_addr", s_addr, 32'h100);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_deliv) break;
    end
    chk("d_dlv", 32'(s_deliv), 32'd1);
    chk("d_dlv_pc", s_dpc, 32'h100);

    // Decode stalls for 5 cycles on the first instruction
    lat = 1;
    reset_pulse("rst_b");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (s_ivld) break;
    end
    chk("e_vld", 32'(s_ivld), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("e_hold_vld", 32'(s_ivld), 32'd1);
      chk("e_hold_instr", s_instr, 32'h0050_0093);
      chk("e_hold_pc", s_dpc, 32'h0);
      chk("e_hold_noreq", 32'(s_req), 32'd0);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("e_acc", 32'(s_deliv), 32'd1);
    wait_req("e_req_after");
    chk("e_addr", s_addr, 32'h4);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (s_ivld) break;
    end
    chk("e_vld2", 32'(s_ivld), 32'd1);

    // Asynchronous reset while an instruction is held
    reset_pulse("rst_hold");

    // Misaligned redirect target
    wait_req("g_sync");
    step(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h0);
      if (s_req) n++;
    end
    chk("g_mis", 32'(s_mis), 32'd1);
    chk("g_noreq", n, 32'd0);
    chk("g_ivld", 32'(s_ivld), 32'd0);
`else
    wait_req("g_req_seen");
    chk("g_addr", s_addr, 32'h100);
    chk("g_mis", 32'(s_mis), 32'd0);
`endif
    reset_pulse("rst_c");

    // Randomized traffic
    nd = ndeliv;
    for (int i = 0; i < 3000; i++) begin
      lat = $urandom_range(1, 4);
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 13) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_MISALIGN_CHECK_EN
      rpc = rpc & ~32'h3;
`endif
      step(rdy, rd, rpc);
    end
    chk("h_progress", 32'((ndeliv - nd) >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the control unit and register file. Holds the program counter, issues single-outstanding reads to instruction memory, and presents one instruction at a time to decode through a valid/ready handshake. Accepts a PC redirect from the execute-side branch logic (the control unit's PCSrc with the computed target) and discards any wrong-path fetch in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_WIDTH, 32, width of PC and memory address
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- imem_req  output  1  read request, one-cycle pulse
- imem_addr  output  ADDR_WIDTH  read address, equals pc while imem_req=1
- imem_valid  input  1  read data returned this cycle
- imem_rdata  input  32  instruction word, sampled when imem_valid=1
- instr_valid  output  1  instr/instr_pc hold a valid instruction
- instr_ready  input  1  decode accepts instruction this cycle
- instr  output  32  instruction word to decode
- instr_pc  output  ADDR_WIDTH  address of instr
- redirect  input  1  take redirect_pc (PCSrc)
- redirect_pc  input  ADDR_WIDTH  branch/jump target
- fetch_misalign  output  1  sticky misaligned-target flag (see Configuration)

## Operation
- States: S_REQ, S_WAIT, S_HOLD, S_HALT.
- S_REQ: imem_req=1, imem_addr=pc; next S_WAIT.
- S_WAIT: on imem_valid, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps modulo 2^ADDR_WIDTH); next S_HOLD. imem_valid outside S_WAIT is ignored.
- S_HOLD: instr/instr_pc stable while instr_valid & !instr_ready; transfer when both high -> instr_valid<=0, next S_REQ.
- Redirect (any state except S_HALT): pc<=redirect_pc, instr_valid<=0, next S_REQ; a transfer in the same cycle counts as consumed. If redirect occurs in S_WAIT with no imem_valid that cycle, set drop flag; the next imem_valid response is discarded before the new request is sent (state waits in S_WAIT with drop set, then S_REQ). Redirect coincident with imem_valid: response discarded, no drop flag.
- Redirect wins over all other transitions.
- Reset mid-operation: all state cleared immediately; in-flight response after reset is ignored (drop flag not needed—memory is reset on the same rst).

## Timing
- Reset values: pc=RESET_PC, state=S_REQ, imem_req=0 while rst=0, instr_valid=0, instr=32'h0000_0013, instr_pc=RESET_PC, drop=0, fetch_misalign=0.
- First imem_req in first clock after rst deasserts.
- imem_valid in cycle k -> instr_valid high from cycle k+1.
- Peak throughput with 1-cycle memory: one instruction per 3 cycles.
- redirect in cycle k -> instr_valid low at k+1, imem_req with redirect_pc at k+1 (or after discarded response if drop set).

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1, state=S_HALT, instr_valid=0, no further requests until reset.
- Undefined: redirect_pc[1:0] forced to 2'b00, fetch_misalign tied 0, S_HALT unreachable.

## Structure
- fetch_pkg: state enum, NOP_INSTR constant (32'h0000_0013), default RESET_PC.
- Sub-module pc_reg: PC register with reset value, +4 increment and redirect load mux.

## Test plan
- Reset release, memory latency 1, instr_ready=1 -> requests at 0x0,0x4,0x8; instr_pc follows, instr_valid once per 3 cycles.
- instr_ready=0 for 5 cycles with instr 0x00500093 held -> instr/instr_pc unchanged, no imem_req until accept.
- Redirect to 0x100 during S_WAIT, memory latency 3 -> stale response discarded, next request addr 0x100, delivered instr_pc=0x100.
- Redirect and imem_valid same cycle -> response not delivered, next imem_addr=redirect_pc.
- With FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> fetch_misalign=1, imem_req stays 0; without macro, request to 0x100.
- rst asserted in S_HOLD -> instr_valid=0 and pc=RESET_PC immediately, asynchronous to clk.
